// File: rtl/sid_bus_regs.sv
// SID bus register interface: write strobes for the register file, read mux with a decaying bus value.
// Optional decay counter enabled by defining SID_BUS_DECAY_EN; otherwise bus value holds until reload or bus_res.
module sid_bus_regs #(
    parameter int unsigned DECAY_CYCLES = 8000,
    parameter logic [4:0]  LAST_REG     = 5'h18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phi2,
    input  logic       bus_we,
    input  logic       bus_oe,
    input  logic       bus_res,
    input  logic [4:0] bus_addr,
    input  logic [7:0] bus_data,
    input  logic       cs_n,
    input  logic [7:0] pot_x,
    input  logic [7:0] pot_y,
    input  logic [7:0] osc3,
    input  logic [7:0] env3,
    output logic       wr_stb,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] data_o
);

    if (DECAY_CYCLES < 1 || DECAY_CYCLES > 65535) begin : g_bad_decay
        $error("DECAY_CYCLES out of range 1..65535");
    end

    logic       we_d_q, oe_d_q, phi2_d_q;
    logic       wr_stb_q, wr_stb_d;
    logic [4:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] data_q, data_d;
    logic [7:0] bus_value_q, bus_value_d;
    logic       bus_load;
    logic [7:0] bus_load_val;
    logic       we_rise, oe_fall, tick, rd_special;
    logic [7:0] rd_sel;

    assign we_rise    = bus_we & ~we_d_q & ~cs_n;
    assign rd_special = (bus_addr >= 5'h19) && (bus_addr <= 5'h1C);
    assign oe_fall    = ~bus_oe & oe_d_q & ~cs_n & rd_special;
    assign tick       = phi2_d_q & ~phi2;

    always_comb begin
        case (bus_addr)
            5'h19:   rd_sel = pot_x;
            5'h1A:   rd_sel = pot_y;
            5'h1B:   rd_sel = osc3;
            5'h1C:   rd_sel = env3;
            default: rd_sel = bus_value_q;
        endcase
    end

    // A read of a live register captures what was driven onto the bus (data_q) as the new bus value.
    always_comb begin
        wr_stb_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        data_d       = data_q;
        bus_load     = 1'b0;
        bus_load_val = bus_value_q;
        if (bus_res) begin
            data_d = 8'h00;
        end else begin
            if (bus_oe && !cs_n) data_d = rd_sel;
            if (we_rise) begin
                bus_load     = 1'b1;
                bus_load_val = bus_data;
                if (bus_addr <= LAST_REG) begin
                    wr_stb_d  = 1'b1;
                    wr_addr_d = bus_addr;
                    wr_data_d = bus_data;
                end
            end else if (oe_fall) begin
                bus_load     = 1'b1;
                bus_load_val = data_q;
            end
        end
    end

`ifdef SID_BUS_DECAY_EN
    logic [15:0] decay_cnt_q, decay_cnt_d;

    always_comb begin
        bus_value_d = bus_value_q;
        decay_cnt_d = decay_cnt_q;
        if (bus_res) begin
            bus_value_d = 8'h00;
            decay_cnt_d = 16'd0;
        end else if (bus_load) begin
            bus_value_d = bus_load_val;
            decay_cnt_d = 16'(DECAY_CYCLES);
        end else if (tick && decay_cnt_q != 16'd0) begin
            decay_cnt_d = decay_cnt_q - 16'd1;
            if (decay_cnt_q == 16'd1) bus_value_d = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) decay_cnt_q <= 16'd0;
        else     decay_cnt_q <= decay_cnt_d;
    end
`else
    logic unused_tick;
    assign unused_tick = tick;

    always_comb begin
        bus_value_d = bus_value_q;
        if (bus_res)       bus_value_d = 8'h00;
        else if (bus_load) bus_value_d = bus_load_val;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_d_q      <= 1'b0;
            oe_d_q      <= 1'b0;
            phi2_d_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 5'h00;
            wr_data_q   <= 8'h00;
            data_q      <= 8'h00;
            bus_value_q <= 8'h00;
        end else begin
            we_d_q      <= bus_we;
            oe_d_q      <= bus_oe;
            phi2_d_q    <= phi2;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            data_q      <= data_d;
            bus_value_q <= bus_value_d;
        end
    end

    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_sid_bus_regs.sv
// Self-checking bench for sid_bus_regs: directed scenarios plus randomized traffic against a bus-event model.
module tb_sid_bus_regs;
    localparam int         DECAY = 4;
    localparam logic [4:0] LAST  = 5'h18;

    logic       clk = 1'b0;
    logic       rst, phi2, bus_we, bus_oe, bus_res, cs_n;
    logic [4:0] bus_addr;
    logic [7:0] bus_data, pot_x, pot_y, osc3, env3;
    logic       wr_stb;
    logic [4:0] wr_addr;
    logic [7:0] wr_data, data_o;

    int n_chk  = 0;
    int n_fail = 0;

    sid_bus_regs #(.DECAY_CYCLES(DECAY), .LAST_REG(LAST)) dut (
        .clk(clk), .rst(rst), .phi2(phi2), .bus_we(bus_we), .bus_oe(bus_oe), .bus_res(bus_res),
        .bus_addr(bus_addr), .bus_data(bus_data), .cs_n(cs_n), .pot_x(pot_x), .pot_y(pot_y),
        .osc3(osc3), .env3(env3), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .data_o(data_o)
    );

    always #5 clk = ~clk;

    // Reference model: the bus value and how many phi2 falls it still survives.
    logic [7:0] m_bus, m_data, m_wdata;
    logic [4:0] m_waddr;
    logic       m_stb, p_we, p_oe, p_phi2;
    int         m_left;

    task automatic model_reset();
        m_bus = 0; m_data = 0; m_wdata = 0; m_waddr = 0; m_stb = 0;
        p_we = 0; p_oe = 0; p_phi2 = 0; m_left = 0;
    endtask

    task automatic model_edge();
        logic [7:0] rd, nd;
        logic       live;
        if (rst) begin model_reset(); return; end
        live = (bus_addr >= 5'h19 && bus_addr <= 5'h1C);
        rd = (bus_addr == 5'h19) ? pot_x : (bus_addr == 5'h1A) ? pot_y :
             (bus_addr == 5'h1B) ? osc3  : (bus_addr == 5'h1C) ? env3 : m_bus;
        nd = m_data;
        m_stb = 0;
        if (bus_res) begin
            m_bus = 0; m_left = 0; nd = 0;
        end else begin
            if (bus_oe && !cs_n) nd = rd;
            if (bus_we && !p_we && !cs_n) begin
                if (bus_addr <= LAST) begin m_stb = 1; m_waddr = bus_addr; m_wdata = bus_data; end
                m_bus = bus_data; m_left = DECAY;
            end else if (!bus_oe && p_oe && !cs_n && live) begin
                m_bus = m_data; m_left = DECAY;
            end else if (p_phi2 && !phi2 && m_left > 0) begin
                m_left = m_left - 1;
`ifdef SID_BUS_DECAY_EN
                if (m_left == 0) m_bus = 0;
`endif
            end
        end
        m_data = nd; p_we = bus_we; p_oe = bus_oe; p_phi2 = phi2;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic phi2_fall();
        phi2 = 1; step();
        phi2 = 0; step();
    endtask

    task automatic test_reset();
        rst = 1; phi2 = 0; bus_we = 0; bus_oe = 0; bus_res = 0; cs_n = 1;
        bus_addr = 0; bus_data = 0; pot_x = 0; pot_y = 0; osc3 = 0; env3 = 0;
        model_reset();
        step(); step();
        n_chk++;
        if ({wr_stb, wr_addr, wr_data, data_o} !== 22'h0) begin
            n_fail++; $display("FAIL reset: got %h expected 0", {wr_stb, wr_addr, wr_data, data_o});
        end
        rst = 0; cs_n = 0; step();
    endtask

    task automatic test_write();
        int extra = 0;
        bus_addr = 5'h04; bus_data = 8'h12; bus_we = 1;
        step();
        n_chk++;
        if (wr_stb !== 1'b1 || wr_addr !== 5'h04 || wr_data !== 8'h12) begin
            n_fail++; $display("FAIL write_strobe: got stb=%b addr=%h data=%h expected 1/04/12", wr_stb, wr_addr, wr_data);
        end
        for (int i = 0; i < 19; i++) begin step(); if (wr_stb) extra++; end
        n_chk++;
        if (extra != 0) begin n_fail++; $display("FAIL write_single: got %0d extra strobes expected 0", extra); end
        bus_we = 0; step();
    endtask

    task automatic test_high_addr();
        int strobes = 0;
        bus_addr = 5'h1D; bus_data = 8'h55; bus_we = 1; step();
        if (wr_stb) strobes++;
        bus_we = 0; step();
        if (wr_stb) strobes++;
        n_chk++;
        if (strobes != 0 || wr_addr !== 5'h04) begin
            n_fail++; $display("FAIL high_addr_nostb: got strobes=%0d addr=%h expected 0/04", strobes, wr_addr);
        end
        bus_oe = 1; step();
        n_chk++;
        if (data_o !== 8'h55) begin n_fail++; $display("FAIL high_addr_read: got %h expected 55", data_o); end
        bus_oe = 0; step();
    endtask

    task automatic test_decay();
        bus_addr = 5'h00; bus_data = 8'hAA; bus_we = 1; step();
        bus_we = 0; step();
        for (int i = 0; i < 3; i++) phi2_fall();
        bus_oe = 1; step();
        n_chk++;
        if (data_o !== 8'hAA) begin n_fail++; $display("FAIL decay_3: got %h expected aa", data_o); end
        bus_oe = 0; step();
        phi2_fall();
        bus_oe = 1; step();
        n_chk++;
`ifdef SID_BUS_DECAY_EN
        if (data_o !== 8'h00) begin n_fail++; $display("FAIL decay_4: got %h expected 00", data_o); end
`else
        if (data_o !== 8'hAA) begin n_fail++; $display("FAIL decay_4: got %h expected aa", data_o); end
`endif
        bus_oe = 0; step();
    endtask

    task automatic test_pot_load();
        pot_x = 8'h7F; bus_addr = 5'h19; bus_oe = 1; step();
        n_chk++;
        if (data_o !== 8'h7F) begin n_fail++; $display("FAIL pot_read: got %h expected 7f", data_o); end
        bus_oe = 0; step();
        pot_x = 8'h00; bus_addr = 5'h00; bus_oe = 1; step();
        n_chk++;
        if (data_o !== 8'h7F) begin n_fail++; $display("FAIL pot_busload: got %h expected 7f", data_o); end
        bus_oe = 0; step();
    endtask

    task automatic test_res_write();
        int strobes = 0;
        bus_addr = 5'h18; bus_data = 8'h33; bus_we = 1; bus_oe = 1; bus_res = 1; step();
        n_chk++;
        if (wr_stb !== 1'b0 || data_o !== 8'h00) begin
            n_fail++; $display("FAIL res_write: got stb=%b data=%h expected 0/00", wr_stb, data_o);
        end
        bus_res = 0; bus_oe = 0;
        for (int i = 0; i < 4; i++) begin step(); if (wr_stb) strobes++; end
        n_chk++;
        if (strobes != 0) begin n_fail++; $display("FAIL res_no_edge: got %0d strobes expected 0", strobes); end
        bus_we = 0; bus_addr = 5'h05; bus_oe = 1; step();
        n_chk++;
        if (data_o !== 8'h00) begin n_fail++; $display("FAIL res_clears_bus: got %h expected 00", data_o); end
        bus_oe = 0; step();
    endtask

    task automatic test_cs();
        int strobes = 0;
        bus_addr = 5'h1E; bus_data = 8'h3C; bus_we = 1; step();
        bus_we = 0; step();
        bus_addr = 5'h02; bus_oe = 1; step();
        bus_oe = 0; cs_n = 1; bus_addr = 5'h01; bus_data = 8'h99; bus_we = 1; step();
        if (wr_stb) strobes++;
        bus_we = 0; bus_oe = 1; step();
        if (wr_stb) strobes++;
        n_chk++;
        if (strobes != 0 || data_o !== 8'h3C) begin
            n_fail++; $display("FAIL cs_blocked: got strobes=%0d data=%h expected 0/3c", strobes, data_o);
        end
        bus_oe = 0; step();
        cs_n = 0; bus_addr = 5'h02; bus_oe = 1; step();
        n_chk++;
        if (data_o !== 8'h3C) begin n_fail++; $display("FAIL cs_bus_kept: got %h expected 3c", data_o); end
        bus_oe = 0; step();
    endtask

    task automatic test_async_rst();
        bus_addr = 5'h03; bus_data = 8'h44; bus_we = 1; bus_oe = 1; step();
        n_chk++;
        if (wr_stb !== 1'b1 || wr_data !== 8'h44) begin
            n_fail++; $display("FAIL arst_pre: got stb=%b data=%h expected 1/44", wr_stb, wr_data);
        end
        #2 rst = 1; bus_we = 0; bus_oe = 0;
        model_reset();
        #1;
        n_chk++;
        if ({wr_stb, wr_addr, wr_data, data_o} !== 22'h0) begin
            n_fail++; $display("FAIL arst_immediate: got %h expected 0", {wr_stb, wr_addr, wr_data, data_o});
        end
        step();
        rst = 0; step();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            phi2 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3) bus_we = ~bus_we;
            if ($urandom_range(0, 9) < 3) bus_oe = ~bus_oe;
            bus_addr = 5'($urandom);
            if (bus_addr < 5'h10 && $urandom_range(0, 1) == 0) bus_addr = 5'h19 + 5'($urandom_range(0, 3));
            bus_data = 8'($urandom);
            cs_n     = ($urandom_range(0, 7) == 0);
            bus_res  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                pot_x = 8'($urandom); pot_y = 8'($urandom); osc3 = 8'($urandom); env3 = 8'($urandom);
            end
            step();
            n_chk++;
            if ({wr_stb, wr_addr, wr_data, data_o} !== {m_stb, m_waddr, m_wdata, m_data}) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got stb=%b addr=%h wdata=%h rdata=%h expected %b/%h/%h/%h",
                             i, wr_stb, wr_addr, wr_data, data_o, m_stb, m_waddr, m_wdata, m_data);
                bad++;
            end
        end
        bus_we = 0; bus_oe = 0; bus_res = 0; cs_n = 0; step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_high_addr();
        test_decay();
        test_pot_load();
        test_res_write();
        test_cs();
        test_async_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
